mipi_raw_unpacker: RTL and testbench

//  Parametrised MIPI CSI-2 RAW unpacker feeding the 3x3 RAW matrix buffer.

---
 rtl/isp_raw_pkg.sv | 29 ++
 rtl/raw_skid_fifo.sv | 54 +++++
 rtl/mipi_raw_unpacker.sv | 106 ++++++++++
 tb/tb_mipi_raw_unpacker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_raw_pkg.sv
// Shared ISP RAW definitions: CSI-2 data-type codes and the pixel bit-depth reducer.
// Build option: MIPI_RAW_ROUND_EN selects round-to-nearest with saturation instead of truncation.
package isp_raw_pkg;

    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;

    // Widths are passed as constants so one function serves every bit-depth pairing.
    function automatic logic [31:0] raw_reduce(input logic [31:0] i_pix,
                                               input int unsigned in_bw,
                                               input int unsigned out_bw);
        int unsigned w_sh;
`ifdef MIPI_RAW_ROUND_EN
        logic [32:0] w_sum;
        logic [32:0] w_max;
`endif
        w_sh = in_bw - out_bw;
`ifdef MIPI_RAW_ROUND_EN
        if (w_sh == 0) return i_pix;
        w_sum = ({1'b0, i_pix} + (33'd1 << (w_sh - 1))) >> w_sh;
        w_max = (33'd1 << out_bw) - 33'd1;
        return (w_sum > w_max) ? w_max[31:0] : w_sum[31:0];
`else
        return i_pix >> w_sh;
`endif
    endfunction

endpackage

// File: rtl/raw_skid_fifo.sv
// Two-entry register FIFO with a registered input ready; entry 0 always drives the output.
module raw_skid_fifo #(
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
);

    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt_nxt;
    logic [DW-1:0] r_mem0;
    logic [DW-1:0] r_mem1;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_valid & r_ready;
    assign w_pop  = (r_cnt != 2'd0) & i_ready;

    always_comb begin
        w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end

    // r_ready tracks r_cnt < 2, so a push never meets a full FIFO.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
            r_mem0  <= '0;
            r_mem1  <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt < 2'd2);
            if (w_pop) begin
                if (r_cnt == 2'd2) r_mem0 <= r_mem1;
                else if (w_push)   r_mem0 <= i_data;
            end else if (w_push) begin
                if (r_cnt == 2'd0) r_mem0 <= i_data;
                else               r_mem1 <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_mem0;
    assign o_valid = (r_cnt != 2'd0);

endmodule

// File: rtl/mipi_raw_unpacker.sv
// CSI-2 RAW unpacker: data-type filter, per-pixel bit reduction, line-length check and SOF counter.
// Build option: MIPI_RAW_ROUND_EN (rounding reduction, see isp_raw_pkg::raw_reduce).
module mipi_raw_unpacker
    import isp_raw_pkg::*;
#(
    parameter int unsigned PIX_PER_CLK = 4,
    parameter int unsigned IN_BW       = 10,
    parameter int unsigned OUT_BW      = 8,
    parameter logic [5:0]  DT_CODE     = DT_RAW10,
    parameter int unsigned EXP_BEATS   = 480,
    parameter int unsigned LCNT_W      = 12
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic [PIX_PER_CLK*IN_BW-1:0]  I_raw_tdata,
    input  logic [9:0]                    I_raw_tdest,
    input  logic                          I_raw_tlast,
    input  logic                          I_raw_tuser,
    input  logic                          I_raw_tvalid,
    output logic                          I_raw_tready,
    output logic [PIX_PER_CLK*OUT_BW-1:0] O_raw_tdata,
    output logic                          O_raw_tlast,
    output logic                          O_raw_tuser,
    output logic                          O_raw_tvalid,
    input  logic                          O_raw_tready,
    output logic                          O_line_err,
    output logic [15:0]                   O_frame_cnt
);

    localparam int unsigned    W_PIX = PIX_PER_CLK * OUT_BW;
    localparam int unsigned    W_FIFO = W_PIX + 2;
    localparam logic [LCNT_W:0] L_EXP = (LCNT_W + 1)'(EXP_BEATS);

    if (OUT_BW > IN_BW) begin : g_bw_check
        $error("mipi_raw_unpacker: OUT_BW must not exceed IN_BW");
    end

    logic [W_PIX-1:0]  w_pix_out;
    logic [OUT_BW-1:0] w_red;
    logic              w_dt_match;
    logic              w_fwd;
    logic              w_in_ready;
    logic [W_FIFO-1:0] w_fifo_out;
    logic [LCNT_W-1:0] r_lcnt;
    logic [LCNT_W-1:0] w_lcnt_base;
    logic [LCNT_W:0]   w_lcnt_inc;
    logic              w_len_bad;
    logic              r_line_err;
    logic [15:0]       r_frame_cnt;
    logic              w_unused_vc;

    assign w_unused_vc = ^I_raw_tdest[9:6];
    assign w_dt_match  = (I_raw_tdest[5:0] == DT_CODE);
    assign w_fwd       = I_raw_tvalid & w_in_ready & w_dt_match;

    // Input pixel k lands in output slot PIX_PER_CLK-1-k so pixel 0 sits in the MS slot.
    always_comb begin
        w_pix_out = '0;
        w_red     = '0;
        for (int unsigned k = 0; k < PIX_PER_CLK; k++) begin
            w_red = OUT_BW'(raw_reduce(32'(I_raw_tdata[k*IN_BW +: IN_BW]), IN_BW, OUT_BW));
            w_pix_out[(PIX_PER_CLK-1-k)*OUT_BW +: OUT_BW] = w_red;
        end
    end

    raw_skid_fifo #(.DW(W_FIFO)) u_fifo (
        .i_clk   (I_clk),
        .i_rst_n (I_rst_n),
        .i_data  ({I_raw_tlast, I_raw_tuser, w_pix_out}),
        .i_valid (I_raw_tvalid & w_dt_match),
        .o_ready (w_in_ready),
        .o_data  (w_fifo_out),
        .o_valid (O_raw_tvalid),
        .i_ready (O_raw_tready)
    );

    // A SOF beat restarts the count and is itself beat one of its line.
    always_comb begin
        w_lcnt_base = I_raw_tuser ? '0 : r_lcnt;
        w_lcnt_inc  = {1'b0, w_lcnt_base} + 1'b1;
        w_len_bad   = (EXP_BEATS != 0) && (w_lcnt_inc != L_EXP);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_lcnt      <= '0;
            r_line_err  <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else if (w_fwd) begin
            if (I_raw_tlast)          r_lcnt <= '0;
            else if (w_lcnt_inc[LCNT_W]) r_lcnt <= '1;
            else                      r_lcnt <= w_lcnt_inc[LCNT_W-1:0];
            if (I_raw_tuser) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (I_raw_tlast && w_len_bad) r_line_err <= 1'b1;
            else if (I_raw_tuser)         r_line_err <= 1'b0;
        end
    end

    assign I_raw_tready = w_in_ready;
    assign O_raw_tlast  = w_fifo_out[W_FIFO-1];
    assign O_raw_tuser  = w_fifo_out[W_FIFO-2];
    assign O_raw_tdata  = w_fifo_out[W_PIX-1:0];
    assign O_line_err   = r_line_err;
    assign O_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_mipi_raw_unpacker.sv
// Directed self-checking bench for mipi_raw_unpacker (4 px/clk, RAW10 -> 8 bit, 4-beat lines).
module tb_mipi_raw_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] in_data = '0;
    logic [9:0]  in_dest = '0;
    logic        in_last = 1'b0, in_user = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_last, out_user, out_valid;
    logic        out_ready = 1'b0;
    logic        line_err;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
        int          cyc;
    } cap_t;
    cap_t        cap_q[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    int          stab_err = 0;
    logic        saw_ready_low = 1'b0;

    mipi_raw_unpacker #(
        .PIX_PER_CLK(4), .IN_BW(10), .OUT_BW(8), .DT_CODE(6'h2B), .EXP_BEATS(4), .LCNT_W(12)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_raw_tdata(in_data), .I_raw_tdest(in_dest), .I_raw_tlast(in_last),
        .I_raw_tuser(in_user), .I_raw_tvalid(in_valid), .I_raw_tready(in_ready),
        .O_raw_tdata(out_data), .O_raw_tlast(out_last), .O_raw_tuser(out_user),
        .O_raw_tvalid(out_valid), .O_raw_tready(out_ready),
        .O_line_err(line_err), .O_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Output monitor: capture transfers, track stall stability, note input back-pressure.
    always @(negedge clk) begin
        if (rst_n && prev_stall && (!out_valid || {out_last, out_user, out_data} !== prev_word))
            stab_err++;
        prev_stall = rst_n && out_valid && !out_ready;
        prev_word  = {out_last, out_user, out_data};
        if (rst_n && out_valid && out_ready) cap_q.push_back('{out_data, out_last, out_user, cycle});
        if (rst_n && !in_ready) saw_ready_low = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] pk_in(input logic [9:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [39:0] beat_in(input int i);
        logic [39:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[k*10 +: 10] = 10'((4*i + k) * 4);
        return v;
    endfunction

    function automatic logic [31:0] beat_out(input int i);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[(3-k)*8 +: 8] = 8'(4*i + k);
        return v;
    endfunction

    task automatic send_beat(input logic [39:0] d, input logic [5:0] dt, input logic l, input logic u);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_data = d; in_dest = {4'h3, dt}; in_last = l; in_user = u; in_valid = 1'b1;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cap_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0", out_data); end
        checks++; if ({out_last, out_user} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {out_last, out_user}); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL rst_line_err: got %b want 0", line_err); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready0: got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready1: got %b want 1", in_ready); end
    endtask

    task automatic test_reduce();
        logic [39:0] d1, d2;
        logic [31:0] e1, e2;
        apply_reset();
        out_ready = 1'b1;
        d1 = pk_in(10'h3FF, 10'h200, 10'h004, 10'h001);
        e1 = 32'hFF800100;
        d2 = pk_in(10'h002, 10'h3FE, 10'h3FC, 10'h0FF);
`ifdef MIPI_RAW_ROUND_EN
        e2 = 32'h01FFFF40;
`else
        e2 = 32'h00FFFF3F;
`endif
        send_beat(d1, 6'h2B, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== e1) begin errors++; $display("FAIL latency_data: got %h want %h", out_data, e1); end
        send_beat(d1, 6'h2B, 1'b0, 1'b0);
        send_beat(d2, 6'h2B, 1'b0, 1'b0);
        send_beat(d1, 6'h2B, 1'b1, 1'b0);
        idle(); idle(); idle();
        checks++;
        if (cap_q.size() != 4) begin
            errors++; $display("FAIL reduce_count: got %0d want 4", cap_q.size());
        end else begin
            checks++; if (cap_q[0].d !== e1) begin errors++; $display("FAIL reduce_b0: got %h want %h", cap_q[0].d, e1); end
            checks++; if (cap_q[1].d !== e1) begin errors++; $display("FAIL reduce_b1: got %h want %h", cap_q[1].d, e1); end
            checks++; if (cap_q[2].d !== e2) begin errors++; $display("FAIL reduce_b2: got %h want %h", cap_q[2].d, e2); end
            checks++; if (cap_q[3].d !== e1) begin errors++; $display("FAIL reduce_b3: got %h want %h", cap_q[3].d, e1); end
            checks++; if (cap_q[3].cyc - cap_q[0].cyc != 3) begin errors++; $display("FAIL throughput: got span %0d want 3", cap_q[3].cyc - cap_q[0].cyc); end
            checks++; if ({cap_q[0].l, cap_q[3].l} !== 2'b01) begin errors++; $display("FAIL tlast_follow: got %b want 01", {cap_q[0].l, cap_q[3].l}); end
        end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL reduce_line_err: got %b want 0", line_err); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        saw_ready_low = 1'b0;
        stab_err = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send_beat(beat_in(i), 6'h2B, (i == 9), (i == 0));
                idle();
            end
            begin
                @(posedge clk); #1 out_ready = 1'b1;
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) idle();
        checks++; if (saw_ready_low !== 1'b1) begin errors++; $display("FAIL bp_ready_drop: got %b want 1", saw_ready_low); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stab_err); end
        checks++;
        if (cap_q.size() != 10) begin
            errors++; $display("FAIL bp_count: got %0d want 10", cap_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (cap_q[i].d !== beat_out(i)) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, cap_q[i].d, beat_out(i));
                end
            end
        end
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL bp_line_err: got %b want 1", line_err); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_line_check();
        logic [39:0] d;
        apply_reset();
        out_ready = 1'b1;
        d = beat_in(1);
        for (int i = 0; i < 4; i++) send_beat(d, 6'h2B, (i == 3), (i == 0));
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL line4_ok: got %b want 0", line_err); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL line_sof1: got %0d want 1", frame_cnt); end
        for (int i = 0; i < 3; i++) send_beat(d, 6'h2B, (i == 2), 1'b0);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL line3_err: got %b want 1", line_err); end
        for (int i = 0; i < 4; i++) send_beat(d, 6'h2B, (i == 3), 1'b0);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL line_err_hold: got %b want 1", line_err); end
        send_beat(d, 6'h2B, 1'b0, 1'b1);
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL sof_clear: got %b want 0", line_err); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL line_sof2: got %0d want 2", frame_cnt); end
        for (int i = 0; i < 3; i++) send_beat(d, 6'h2B, (i == 2), 1'b0);
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL sof_line_ok: got %b want 0", line_err); end
        send_beat(d, 6'h2B, 1'b1, 1'b1);
        checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", line_err); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL line_sof3: got %0d want 3", frame_cnt); end
        idle(); idle();
    endtask

    task automatic test_dt_filter();
        apply_reset();
        out_ready = 1'b1;
        send_beat(beat_in(0), 6'h2B, 1'b0, 1'b1);
        send_beat(beat_in(7), 6'h12, 1'b1, 1'b1);
        send_beat(beat_in(1), 6'h2B, 1'b0, 1'b0);
        send_beat(beat_in(8), 6'h12, 1'b0, 1'b0);
        send_beat(beat_in(2), 6'h2B, 1'b0, 1'b0);
        send_beat(beat_in(3), 6'h2B, 1'b1, 1'b0);
        idle(); idle(); idle();
        checks++;
        if (cap_q.size() != 4) begin
            errors++; $display("FAIL dt_count: got %0d want 4", cap_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap_q[i].d !== beat_out(i)) begin
                    errors++; $display("FAIL dt_data[%0d]: got %h want %h", i, cap_q[i].d, beat_out(i));
                end
            end
            checks++; if ({cap_q[0].u, cap_q[3].l} !== 2'b11) begin errors++; $display("FAIL dt_flags: got %b want 11", {cap_q[0].u, cap_q[3].l}); end
        end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL dt_frame_cnt: got %0d want 1", frame_cnt); end
        checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL dt_line_err: got %b want 0", line_err); end
    endtask

    task automatic test_reset_midline();
        apply_reset();
        out_ready = 1'b0;
        send_beat(beat_in(0), 6'h2B, 1'b0, 1'b1);
        send_beat(beat_in(1), 6'h2B, 1'b0, 1'b0);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", in_ready); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_frame: got %0d want 1", frame_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_frame: got %0d want 0", frame_cnt); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cap_q.delete();
        out_ready = 1'b1;
        send_beat(beat_in(5), 6'h2B, 1'b0, 1'b0);
        idle(); idle();
        checks++;
        if (cap_q.size() != 1) begin
            errors++; $display("FAIL post_rst_count: got %0d want 1", cap_q.size());
        end else begin
            checks++; if (cap_q[0].d !== beat_out(5)) begin errors++; $display("FAIL post_rst_data: got %h want %h", cap_q[0].d, beat_out(5)); end
        end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_frame: got %0d want 0", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_reduce();
        test_back_to_back();
        test_line_check();
        test_dt_filter();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
